// File: rtl/axi_read_arbiter.sv
// Read-side arbiter/sequencer for the 2-master / 2-slave AXI interconnect.
// Grants one AR request at a time (round-robin) and holds it until the RLAST beat.
module axi_read_arbiter #(
    parameter logic [15:0] S0_BASE = 16'h0000,
    parameter logic [15:0] S1_BASE = 16'h0001
) (
    input  logic        ACLK,
    input  logic        ARESETn,
    input  logic        ARVALID_M0,
    input  logic        ARVALID_M1,
    input  logic [31:0] ARADDR_M0,
    input  logic [31:0] ARADDR_M1,
    input  logic        ARREADY_S0,
    input  logic        ARREADY_S1,
    input  logic        ARREADY_DEF,
    input  logic        RVALID_S0,
    input  logic        RVALID_S1,
    input  logic        RVALID_DEF,
    input  logic        RLAST_S0,
    input  logic        RLAST_S1,
    input  logic        RLAST_DEF,
    input  logic        RREADY_M0,
    input  logic        RREADY_M1,
    output logic [1:0]  Read_State,
    output logic [3:0]  ARID_control,
    output logic        AR_GRANT_M0,
    output logic        AR_GRANT_M1,
    output logic [7:0]  RBEATS
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ADDR = 2'b01,
        DATA = 2'b10
    } state_e;

    // Handshake rule: an AR transfer is ARVALID_M<gm> & selected ARREADY while in ADDR;
    // an R beat is selected RVALID & RREADY_M<gm> while in DATA. Other targets are ignored.

    state_e      state_q, state_d;
    logic        gm_q, gm_d;
    logic [2:0]  tgt_q, tgt_d;
    logic        rr_q, rr_d;
    logic [7:0]  rbeats_q, rbeats_d;

    logic        win;
    logic        arvalid_gm;
    logic        rready_gm;
    logic        arready_sel;
    logic        rvalid_sel;
    logic        rlast_sel;
    logic        beat;
    logic        unused_addr_bits;

    // Only the page bits take part in target decode.
    assign unused_addr_bits = ^{ARADDR_M0[15:0], ARADDR_M1[15:0]};

    function automatic logic [2:0] decode_tgt(input logic [15:0] page);
        if (page == S0_BASE) begin
            return 3'b001;
        end else if (page == S1_BASE) begin
            return 3'b010;
        end else begin
            return 3'b100;
        end
    endfunction

    assign arvalid_gm  = gm_q ? ARVALID_M1 : ARVALID_M0;
    assign rready_gm   = gm_q ? RREADY_M1  : RREADY_M0;
    assign arready_sel = |(tgt_q & {ARREADY_DEF, ARREADY_S1, ARREADY_S0});
    assign rvalid_sel  = |(tgt_q & {RVALID_DEF,  RVALID_S1,  RVALID_S0});
    assign rlast_sel   = |(tgt_q & {RLAST_DEF,   RLAST_S1,   RLAST_S0});
    assign beat        = rvalid_sel & rready_gm;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q  <= IDLE;
            gm_q     <= 1'b0;
            tgt_q    <= 3'b000;
            rr_q     <= 1'b0;
            rbeats_q <= 8'h00;
        end else begin
            state_q  <= state_d;
            gm_q     <= gm_d;
            tgt_q    <= tgt_d;
            rr_q     <= rr_d;
            rbeats_q <= rbeats_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        gm_d     = gm_q;
        tgt_d    = tgt_q;
        rr_d     = rr_q;
        rbeats_d = rbeats_q;
        win      = 1'b0;
        case (state_q)
            IDLE: begin
                if (ARVALID_M0 || ARVALID_M1) begin
                    // Contention resolved by rr; a lone request always wins.
                    win      = (ARVALID_M0 && ARVALID_M1) ? rr_q : ARVALID_M1;
                    gm_d     = win;
                    tgt_d    = decode_tgt(win ? ARADDR_M1[31:16] : ARADDR_M0[31:16]);
                    rbeats_d = 8'h00;
                    state_d  = ADDR;
                end
            end
            ADDR: begin
                // A master withdrawing its request abandons the grant; rr is untouched.
                if (!arvalid_gm) begin
                    state_d = IDLE;
                end else if (arready_sel) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (beat) begin
                    if (rbeats_q != 8'hFF) begin
                        rbeats_d = rbeats_q + 8'h01;
                    end
                    if (rlast_sel) begin
                        state_d = IDLE;
                        rr_d    = ~gm_q;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign Read_State   = state_q;
    assign ARID_control = (state_q == IDLE) ? 4'b0000 : {gm_q, tgt_q};
    assign AR_GRANT_M0  = (state_q == ADDR) && !gm_q;
    assign AR_GRANT_M1  = (state_q == ADDR) &&  gm_q;
    assign RBEATS       = rbeats_q;

endmodule

// File: doc/axi_read_arbiter.md
# axi_read_arbiter

Read-side arbiter and sequencer for the two-master / two-slave AXI interconnect. Grants one master's AR request at a time using round-robin priority and decodes the target (S0, S1 or default slave) from ARADDR. It holds the grant until the final read beat (RLAST handshake) completes. It drives the 2-bit read state and 4-bit ARID routing code consumed by the interconnect's read address and read data channel muxes.

## Interface
Parameters:
- S0_BASE, 16'h0000, ARADDR[31:16] value selecting slave S0
- S1_BASE, 16'h0001, ARADDR[31:16] value selecting slave S1; any other value selects the default slave

Ports:
- ACLK  in  1  clock
- ARESETn  in  1  reset, asynchronous, active-low
- ARVALID_M0, ARVALID_M1  in  1  master read-address requests
- ARADDR_M0, ARADDR_M1  in  32  master read addresses
- ARREADY_S0, ARREADY_S1, ARREADY_DEF  in  1  target address-ready
- RVALID_S0, RVALID_S1, RVALID_DEF  in  1  target read-data valid
- RLAST_S0, RLAST_S1, RLAST_DEF  in  1  target last-beat flag
- RREADY_M0, RREADY_M1  in  1  master read-data ready
- Read_State  out  2  2'b00 IDLE, 2'b01 ADDR, 2'b10 DATA
- ARID_control  out  4  bit3 is the granted master (0 = M0, 1 = M1); bits[2:0] are the one-hot target (001 = S0, 010 = S1, 100 = default); 4'b0000 when idle
- AR_GRANT_M0, AR_GRANT_M1  out  1  the master's AR channel is connected to the target during ADDR
- RBEATS  out  8  handshaked data beats in the current transaction

## Operation
- Registers: state, granted master (gm), target (tgt, 3-bit one-hot), round-robin pointer (rr; 0 favours M0), RBEATS.
- IDLE:
  - If exactly one ARVALID is asserted, grant that master.
  - If both are asserted, grant M0 when rr = 0 and M1 when rr = 1.
  - Latch gm, and latch tgt decoded from the winner's ARADDR[31:16]. Clear RBEATS. Go to ADDR.
  - With no request, stay in IDLE.
- ADDR:
  - ARID_control = {gm, tgt}. AR_GRANT_M<gm> = 1.
  - When ARVALID_M<gm> and the selected target's ARREADY are both high, go to DATA.
  - If ARVALID_M<gm> deasserts before ARREADY, return to IDLE with rr unchanged. This is a protocol violation tolerated without lockup.
  - ARREADY from non-selected targets is ignored.
- DATA:
  - ARID_control is held. AR_GRANT_* = 0.
  - A beat is selected RVALID and RREADY_M<gm> high together. Each beat increments RBEATS, saturating at 8'hFF.
  - A beat with the selected RLAST high returns the block to IDLE and sets rr = ~gm.
  - RVALID/RLAST from non-selected targets are ignored.
- Decode: S0 when ARADDR[31:16] == S0_BASE, else S1 when == S1_BASE, else default. S0 takes precedence if both bases are equal.
- Only one outstanding read is allowed system-wide. New ARVALIDs wait in IDLE.

## Timing
- Reset (async, immediate): Read_State = 2'b00, ARID_control = 4'b0000, AR_GRANT_M0/M1 = 0, RBEATS = 0, rr = 0.
  - Reset asserted mid-transaction aborts it with no drain.
- All outputs are registered state or pure decode of registered state. There is no combinational path from inputs to outputs.
- ARVALID sampled in IDLE at edge n: Read_State = ADDR and ARID_control is valid after edge n.
- ARREADY sampled at edge n+k (k ≥ 1): DATA after that edge.
- Last beat at edge m: IDLE after edge m.
- Minimum transaction of 1 beat: 3 cycles (IDLE, ADDR, DATA).
- Back-to-back transactions: exactly one IDLE cycle between the last beat and the next grant.
- Simultaneous last beat and new ARVALID: the new request is arbitrated in the following IDLE cycle using the updated rr.
- RBEATS keeps its value in IDLE until the next grant.

## Test plan
- Reset, then ARVALID_M0 with ARADDR_M0 = 32'h0000_0010; ARREADY_S0 one cycle later; 4 beats with RLAST on the 4th:
  - ARID_control = 4'b0001 in ADDR and DATA; RBEATS = 4; back to IDLE; rr = 1.
- ARVALID_M0 and ARVALID_M1 both held high continuously, both to S1 (32'h0001_0000), 1-beat bursts:
  - Grants alternate M0, M1, M0 with ARID_control 4'b0010, 4'b1010, 4'b0010.
  - One IDLE cycle between transactions.
- ARVALID_M1 with ARADDR_M1 = 32'h2000_0000:
  - ARID_control = 4'b1100; completes on ARREADY_DEF and RLAST_DEF.
  - RVALID_S0 pulses during DATA are ignored.
- In DATA, RVALID_S1 high with RREADY_M0 low for 5 cycles, then RREADY_M0 high with RLAST_S1:
  - RBEATS stays 0 during the stall, becomes 1, then IDLE.
- ARVALID_M1 deasserted in ADDR before ARREADY:
  - Returns to IDLE with rr unchanged.
- ARESETn asserted mid-DATA:
  - Same cycle: all outputs 0, Read_State = 2'b00.
  - After release, M0 wins a simultaneous request.
